// File: rtl/sfif_capture_ctrl_pkg.sv
// rtl/sfif_capture_ctrl_pkg.sv - shared state codes and register map for the sfif capture controller
//
// Purpose : definitions shared by sfif_capture_ctrl, sfif_capture_trig and the
//           sfif_wbs register decode (state codes, state width, register offsets).
// Ports   : none (package).
// Config  : CAPTURE_LEVEL_TRIG_EN is not referenced here.
package sfif_capture_ctrl_pkg;

  localparam int CAP_STATE_W = 3;

  typedef enum logic [CAP_STATE_W-1:0] {
    CAP_IDLE  = 3'd0,
    CAP_FILL  = 3'd1,
    CAP_ARMED = 3'd2,
    CAP_POST  = 3'd3,
    CAP_DONE  = 3'd4
  } cap_state_e;

  // Byte offsets of the capture registers inside the sfif_wbs window.
  localparam logic [7:0] CAP_REG_CTRL   = 8'h00;
  localparam logic [7:0] CAP_REG_STATUS = 8'h04;
  localparam logic [7:0] CAP_REG_PRE    = 8'h08;
  localparam logic [7:0] CAP_REG_POST   = 8'h0C;
  localparam logic [7:0] CAP_REG_BASE   = 8'h10;

  // States in which incoming samples are written to the capture RAM.
  function automatic logic cap_is_busy(input cap_state_e st);
    return (st == CAP_FILL) || (st == CAP_ARMED) || (st == CAP_POST);
  endfunction

endpackage

// File: rtl/sfif_capture_ctrl_trig.sv
// rtl/sfif_capture_ctrl_trig.sv - trigger detector for the sfif capture controller
//
// Purpose : module sfif_capture_trig. Produces a one-cycle trigger strobe from
//           the rising edge of trig_i, qualified by sample_valid_i. With
//           CAPTURE_LEVEL_TRIG_EN defined, also fires when a valid sample
//           crosses level_thresh_i upwards (unsigned compare) and ORs both.
// Ports   : wb_clk_i, wb_rst_i (async, active-high)
//           trig_i          external trigger level
//           sample_valid_i  sample qualifier
//           sample_i        sample value      (CAPTURE_LEVEL_TRIG_EN only)
//           level_thresh_i  level threshold   (CAPTURE_LEVEL_TRIG_EN only)
//           trig_o          trigger strobe, combinational
// Config  : CAPTURE_LEVEL_TRIG_EN
module sfif_capture_trig #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    trig_i,
  input  logic                    sample_valid_i,
`ifdef CAPTURE_LEVEL_TRIG_EN
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic [SAMPLE_WIDTH-1:0] level_thresh_i,
`endif
  output logic                    trig_o
);

  logic trig_prev_q;
  logic edge_trig;

  // trig_i is sampled every cycle, so a level held across idle cycles
  // does not re-fire when samples resume.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      trig_prev_q <= 1'b0;
    end else begin
      trig_prev_q <= trig_i;
    end
  end

  assign edge_trig = sample_valid_i & trig_i & ~trig_prev_q;

`ifdef CAPTURE_LEVEL_TRIG_EN
  logic [SAMPLE_WIDTH-1:0] prev_sample_q;
  logic                    level_trig;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      prev_sample_q <= '0;
    end else if (sample_valid_i) begin
      prev_sample_q <= sample_i;
    end
  end

  assign level_trig = sample_valid_i & (sample_i >= level_thresh_i) &
                      (prev_sample_q < level_thresh_i);
  assign trig_o     = edge_trig | level_trig;
`else
  assign trig_o     = edge_trig;
`endif

endmodule

// File: rtl/sfif_capture_ctrl.sv
// rtl/sfif_capture_ctrl.sv - capture sequencer driving the adc_ram write port
//
// Purpose : arm / pre-trigger fill / trigger / post-trigger count / freeze.
//           Publishes capture_base_o (oldest sample address) as the read head.
// Ports   : wb_clk_i, wb_rst_i (async, active-high)
//           arm_i, abort_i              1-cycle command pulses
//           pre_trig_i, post_trig_i     capture geometry, latched at arm
//           trig_i, sample_valid_i, sample_i
//           level_thresh_i              (CAPTURE_LEVEL_TRIG_EN only)
//           ram_we_o, ram_wr_addr_o, ram_wr_data_o   registered RAM write port
//           capture_base_o, done_o, busy_o, cfg_err_o, state_o
// Config  : CAPTURE_LEVEL_TRIG_EN adds the level_thresh_i input and the
//           threshold-crossing trigger.
module sfif_capture_ctrl
  import sfif_capture_ctrl_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int PTR_BITS     = 10
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic [PTR_BITS-1:0]     pre_trig_i,
  input  logic [PTR_BITS-1:0]     post_trig_i,
  input  logic                    trig_i,
  input  logic                    sample_valid_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
`ifdef CAPTURE_LEVEL_TRIG_EN
  input  logic [SAMPLE_WIDTH-1:0] level_thresh_i,
`endif
  output logic                    ram_we_o,
  output logic [PTR_BITS-1:0]     ram_wr_addr_o,
  output logic [SAMPLE_WIDTH-1:0] ram_wr_data_o,
  output logic [PTR_BITS-1:0]     capture_base_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    cfg_err_o,
  output logic [CAP_STATE_W-1:0]  state_o
);

  localparam logic [PTR_BITS-1:0] PTR_ZERO = '0;
  localparam logic [PTR_BITS-1:0] PTR_ONE  = {{(PTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [PTR_BITS:0]   DEPTH    = {1'b1, {PTR_BITS{1'b0}}};

  cap_state_e              state_q, state_d;
  logic [PTR_BITS-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]     pre_q, pre_d;
  logic [PTR_BITS-1:0]     post_q, post_d;
  logic [PTR_BITS-1:0]     pre_cnt_q, pre_cnt_d;
  logic [PTR_BITS-1:0]     post_cnt_q, post_cnt_d;
  logic [PTR_BITS-1:0]     trig_addr_q, trig_addr_d;
  logic [PTR_BITS-1:0]     base_q, base_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    done_q, busy_q;
  logic                    ram_we_q;
  logic [PTR_BITS-1:0]     ram_wr_addr_q, ram_wr_addr_d;
  logic [SAMPLE_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;

  logic                    trig_hit;
  logic                    wr_en;
  logic                    arm_ok_state;
  logic [PTR_BITS-1:0]     post_eff;
  logic [PTR_BITS:0]       cfg_sum;
  logic                    cfg_bad;

  sfif_capture_trig #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_trig (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .trig_i         (trig_i),
    .sample_valid_i (sample_valid_i),
`ifdef CAPTURE_LEVEL_TRIG_EN
    .sample_i       (sample_i),
    .level_thresh_i (level_thresh_i),
`endif
    .trig_o         (trig_hit)
  );

  // A post-trigger length of 0 still keeps the trigger sample itself.
  assign post_eff = (post_trig_i == PTR_ZERO) ? PTR_ONE : post_trig_i;

  // One extra bit so a geometry of exactly the RAM depth is not mistaken
  // for an overflow.
  assign cfg_sum = {1'b0, pre_trig_i} + {1'b0, post_eff};
  assign cfg_bad = (cfg_sum > DEPTH);

  assign arm_ok_state = (state_q == CAP_IDLE) || (state_q == CAP_DONE);

  // abort wins over a sample arriving in the same cycle; the write already
  // sitting on the RAM port is left to complete.
  assign wr_en = sample_valid_i & ~abort_i & cap_is_busy(state_q);

  assign wr_ptr_d      = wr_ptr_q + {{(PTR_BITS-1){1'b0}}, wr_en};
  assign ram_wr_addr_d = wr_en ? wr_ptr_q : ram_wr_addr_q;
  assign ram_wr_data_d = wr_en ? sample_i : ram_wr_data_q;

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    post_d      = post_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    base_d      = base_q;
    cfg_err_d   = cfg_err_q;

    if (abort_i) begin
      state_d = CAP_IDLE;
    end else if (arm_i && arm_ok_state) begin
      pre_d     = pre_trig_i;
      post_d    = post_eff;
      pre_cnt_d = PTR_ZERO;
      cfg_err_d = cfg_bad;
      if (!cfg_bad) begin
        state_d = (pre_trig_i == PTR_ZERO) ? CAP_ARMED : CAP_FILL;
      end
    end else begin
      case (state_q)
        CAP_FILL: begin
          if (wr_en) begin
            pre_cnt_d = pre_cnt_q + PTR_ONE;
            if (pre_cnt_d == pre_q) begin
              state_d = CAP_ARMED;
            end
          end
        end
        CAP_ARMED: begin
          // trig_hit implies a valid sample, so the trigger sample is
          // written this cycle at wr_ptr_q and counts as the first post sample.
          if (trig_hit) begin
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = post_q - PTR_ONE;
            if (post_q == PTR_ONE) begin
              state_d = CAP_DONE;
              base_d  = wr_ptr_q - pre_q;
            end else begin
              state_d = CAP_POST;
            end
          end
        end
        CAP_POST: begin
          // post_cnt_q holds the samples still owed after the trigger;
          // the write that takes it to zero is the last one.
          if (wr_en) begin
            post_cnt_d = post_cnt_q - PTR_ONE;
            if (post_cnt_q == PTR_ONE) begin
              state_d = CAP_DONE;
              base_d  = trig_addr_q - pre_q;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= CAP_IDLE;
      wr_ptr_q      <= '0;
      pre_q         <= '0;
      post_q        <= '0;
      pre_cnt_q     <= '0;
      post_cnt_q    <= '0;
      trig_addr_q   <= '0;
      base_q        <= '0;
      cfg_err_q     <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      pre_q         <= pre_d;
      post_q        <= post_d;
      pre_cnt_q     <= pre_cnt_d;
      post_cnt_q    <= post_cnt_d;
      trig_addr_q   <= trig_addr_d;
      base_q        <= base_d;
      cfg_err_q     <= cfg_err_d;
      done_q        <= (state_d == CAP_DONE);
      busy_q        <= cap_is_busy(state_d);
      ram_we_q      <= wr_en;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
    end
  end

  assign ram_we_o       = ram_we_q;
  assign ram_wr_addr_o  = ram_wr_addr_q;
  assign ram_wr_data_o  = ram_wr_data_q;
  assign capture_base_o = base_q;
  assign done_o         = done_q;
  assign busy_o         = busy_q;
  assign cfg_err_o      = cfg_err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sfif_capture_ctrl.sv
// tb/tb_sfif_capture_ctrl.sv - self-checking bench for sfif_capture_ctrl
module tb_sfif_capture_ctrl;

  localparam int SW    = 16;
  localparam int PB    = 10;
  localparam int DEPTH = 1 << PB;

  logic          clk;
  logic          rst;
  logic          arm, abort, trig, valid;
  logic [PB-1:0] pre, post;
  logic [SW-1:0] sample;
`ifdef CAPTURE_LEVEL_TRIG_EN
  logic [SW-1:0] thresh;
`endif
  logic          ram_we;
  logic [PB-1:0] ram_addr;
  logic [SW-1:0] ram_data;
  logic [PB-1:0] base;
  logic          done, busy, cfg_err;
  logic [2:0]    state;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  sfif_capture_ctrl #(.SAMPLE_WIDTH(SW), .PTR_BITS(PB)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .arm_i          (arm),
    .abort_i        (abort),
    .pre_trig_i     (pre),
    .post_trig_i    (post),
    .trig_i         (trig),
    .sample_valid_i (valid),
    .sample_i       (sample),
`ifdef CAPTURE_LEVEL_TRIG_EN
    .level_thresh_i (thresh),
`endif
    .ram_we_o       (ram_we),
    .ram_wr_addr_o  (ram_addr),
    .ram_wr_data_o  (ram_data),
    .capture_base_o (base),
    .done_o         (done),
    .busy_o         (busy),
    .cfg_err_o      (cfg_err),
    .state_o        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers are the published state codes; the capture is described
  // in terms of samples kept before the trigger and samples still owed after it.
  int m_phase, m_next_addr, m_keep_before, m_keep_after, m_kept, m_owed;
  int m_trig_at, m_base, m_addr, m_data;
  bit m_we, m_err, m_trig_was_high;
  int m_last_sample;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_next_addr = 0; m_keep_before = 0; m_keep_after = 0;
      m_kept = 0; m_owed = 0; m_trig_at = 0; m_base = 0; m_addr = 0;
      m_data = 0; m_we = 0; m_err = 0; m_trig_was_high = 0; m_last_sample = 0;
    end else begin
      bit hit, wrote;
      int here, want_after;
      hit = valid && trig && !m_trig_was_high;
`ifdef CAPTURE_LEVEL_TRIG_EN
      hit = hit || (valid && int'(sample) >= int'(thresh) && m_last_sample < int'(thresh));
`endif
      wrote = valid && !abort && (m_phase >= 1 && m_phase <= 3);
      here  = m_next_addr;
      m_we  = wrote;
      if (wrote) begin
        m_addr = here; m_data = int'(sample);
        m_next_addr = (m_next_addr + 1) % DEPTH;
      end
      if (abort) begin
        m_phase = 0;
      end else if (arm && (m_phase == 0 || m_phase == 4)) begin
        want_after = (post == 0) ? 1 : int'(post);
        m_err = (int'(pre) + want_after > DEPTH);
        if (!m_err) begin
          m_keep_before = int'(pre); m_keep_after = want_after; m_kept = 0;
          m_phase = (pre == 0) ? 2 : 1;
        end
      end else if (m_phase == 1) begin
        if (wrote) begin
          m_kept++;
          if (m_kept == m_keep_before) m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (hit) begin
          m_trig_at = here;
          m_owed = m_keep_after - 1;
          if (m_owed == 0) begin
            m_phase = 4;
            m_base = (m_trig_at - m_keep_before + DEPTH) % DEPTH;
          end else begin
            m_phase = 3;
          end
        end
      end else if (m_phase == 3) begin
        if (wrote) begin
          m_owed--;
          if (m_owed == 0) begin
            m_phase = 4;
            m_base = (m_trig_at - m_keep_before + DEPTH) % DEPTH;
          end
        end
      end
      m_trig_was_high = trig;
      if (valid) m_last_sample = int'(sample);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("state_o", int'(state), m_phase);
    chk("done_o", int'(done), (m_phase == 4) ? 1 : 0);
    chk("busy_o", int'(busy), (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
    chk("cfg_err_o", int'(cfg_err), int'(m_err));
    chk("ram_we_o", int'(ram_we), int'(m_we));
    if (m_we) begin
      chk("ram_wr_addr_o", int'(ram_addr), m_addr);
      chk("ram_wr_data_o", int'(ram_data), m_data);
    end
    if (m_phase == 4) chk("capture_base_o", int'(base), m_base);
    if (ram_we === 1'b1) wr_count++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit a, input bit ab, input bit v, input bit t,
                     input logic [SW-1:0] s);
    arm = a; abort = ab; valid = v; trig = t; sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
  endtask

  int trig_pulses;

  initial begin
    rst = 1; arm = 0; abort = 0; trig = 0; valid = 0; sample = '0;
    pre = '0; post = '0;
`ifdef CAPTURE_LEVEL_TRIG_EN
    thresh = 16'h0080;
`endif
    #23;
    chk("reset state_o", int'(state), 0);
    chk("reset ram_we_o", int'(ram_we), 0);
    chk("reset base", int'(base), 0);
    @(posedge clk); #1;
    rst = 0;
    idle(2);

    // pre=4 post=4, stray trigger in FILL, real trigger on 7th sample
    pre = 10'd4; post = 10'd4;
    cyc(1, 0, 0, 0, '0);
    chk("s1 state after arm", int'(state), 1);
    wr_count = 0;
    for (int i = 1; i <= 12; i++)
      cyc(0, 0, 1, (i == 2 || i == 7), SW'(16'h1000 + i));
    idle(2);
    chk("s1 writes", wr_count, 10);
    chk("s1 base", int'(base), 2);
    chk("s1 model base", m_base, 2);
    chk("s1 done", int'(done), 1);

    // pre=0 post=0 from DONE: straight to ARMED, single write
    pre = 10'd0; post = 10'd0;
    cyc(1, 0, 0, 0, '0);
    chk("s2 state after arm", int'(state), 2);
    wr_count = 0;
    cyc(0, 0, 1, 1, 16'h2001);
    cyc(0, 0, 1, 0, 16'h2002);
    cyc(0, 0, 1, 0, 16'h2003);
    idle(2);
    chk("s2 writes", wr_count, 1);
    chk("s2 base", int'(base), 10);
    chk("s2 state", int'(state), 4);

    // rejected geometry
    cyc(0, 1, 0, 0, '0);
    chk("s3 abort to idle", int'(state), 0);
    pre = 10'd1000; post = 10'd100;
    cyc(1, 0, 0, 0, '0);
    chk("s3 cfg_err", int'(cfg_err), 1);
    chk("s3 state", int'(state), 0);

    // abort + arm + trigger in ARMED
    pre = 10'd0; post = 10'd2;
    cyc(1, 0, 0, 0, '0);
    chk("s4 armed", int'(state), 2);
    chk("s4 cfg_err cleared", int'(cfg_err), 0);
    wr_count = 0;
    cyc(1, 1, 1, 1, 16'h3001);
    chk("s4 idle", int'(state), 0);
    chk("s4 done", int'(done), 0);
    idle(2);
    chk("s4 writes", wr_count, 0);

    // advance wr_ptr to 1020 with a 1009-sample capture
    pre = 10'd0; post = 10'd1009;
    cyc(1, 0, 0, 0, '0);
    wr_count = 0;
    for (int i = 0; i < 1009; i++) cyc(0, 0, 1, (i == 0), SW'(16'h4000 + i));
    idle(2);
    chk("s5a writes", wr_count, 1009);
    chk("s5a base", int'(base), 11);

    // wrap: pre=1000 post=24 from wr_ptr=1020
    pre = 10'd1000; post = 10'd24;
    cyc(1, 0, 0, 0, '0);
    chk("s5 cfg_err", int'(cfg_err), 0);
    chk("s5 fill", int'(state), 1);
    wr_count = 0;
    for (int i = 1; i <= 1030; i++) cyc(0, 0, 1, (i == 1001), SW'(16'h5000 + i));
    idle(2);
    chk("s5 writes", wr_count, 1024);
    chk("s5 base", int'(base), 1020);
    chk("s5 done", int'(done), 1);

    // asynchronous reset mid-POST
    pre = 10'd0; post = 10'd10;
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 1, 1, 16'h6001);
    cyc(0, 0, 1, 0, 16'h6002);
    cyc(0, 0, 1, 0, 16'h6003);
    chk("s6 in post", int'(state), 3);
    #2;
    rst = 1;
    #1;
    chk("s6 async state", int'(state), 0);
    chk("s6 async we", int'(ram_we), 0);
    chk("s6 async busy", int'(busy), 0);
    chk("s6 async addr", int'(ram_addr), 0);
    wr_count = 0;
    cyc(0, 0, 1, 0, 16'h6004);
    cyc(0, 0, 1, 0, 16'h6005);
    rst = 0;
    idle(2);
    chk("s6 no writes", wr_count, 0);

`ifdef CAPTURE_LEVEL_TRIG_EN
    // level trigger: only the upward crossing at 0x80 fires
    pre = 10'd0; post = 10'd2;
    cyc(1, 0, 0, 0, '0);
    wr_count = 0;
    trig_pulses = 0;
    begin
      logic [SW-1:0] lv [4];
      lv[0] = 16'h0070; lv[1] = 16'h007F; lv[2] = 16'h0080; lv[3] = 16'h0090;
      for (int i = 0; i < 4; i++) begin
        arm = 0; abort = 0; trig = 0; valid = 1; sample = lv[i];
        #1;
        if (dut.u_trig.trig_o === 1'b1) trig_pulses++;
        @(posedge clk); #1;
      end
    end
    idle(2);
    chk("lvl trig pulses", trig_pulses, 1);
    chk("lvl writes", wr_count, 4);
    chk("lvl base", int'(base), 2);
`else
    trig_pulses = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
